// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encode/decode definitions.
// Holds the opcode, ALU-op and funct constants the decoder consumes, the
// descriptor kind codes used by instr_encoder, the FIFO entry layout and
// small helpers for mapping ALU ops to funct fields and range-checking
// immediates.
package instr_encoder_pkg;

    // Major opcodes
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    // ALU operation codes (the set-compare ops double as branch conditions)
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_SEQ  = 4'd10;
    localparam logic [3:0] ALU_SNE  = 4'd11;
    localparam logic [3:0] ALU_SGE  = 4'd12;
    localparam logic [3:0] ALU_SGEU = 4'd13;

    // funct3 values
    localparam logic [2:0] INST_ADD_FUNCT  = 3'b000;
    localparam logic [2:0] INST_SLL_FUNCT  = 3'b001;
    localparam logic [2:0] INST_SLT_FUNCT  = 3'b010;
    localparam logic [2:0] INST_SLTU_FUNCT = 3'b011;
    localparam logic [2:0] INST_XOR_FUNCT  = 3'b100;
    localparam logic [2:0] INST_SR_FUNCT   = 3'b101;
    localparam logic [2:0] INST_OR_FUNCT   = 3'b110;
    localparam logic [2:0] INST_AND_FUNCT  = 3'b111;
    localparam logic [2:0] INST_LW_FUNCT   = 3'b010;
    localparam logic [2:0] INST_SW_FUNCT   = 3'b010;
    localparam logic [2:0] INST_BEQ_FUNCT  = 3'b000;
    localparam logic [2:0] INST_BNE_FUNCT  = 3'b001;
    localparam logic [2:0] INST_BLT_FUNCT  = 3'b100;
    localparam logic [2:0] INST_BGE_FUNCT  = 3'b101;
    localparam logic [2:0] INST_BLTU_FUNCT = 3'b110;
    localparam logic [2:0] INST_BGEU_FUNCT = 3'b111;

    // funct7: ALT selects SUB / SRA / SRAI
    localparam logic [6:0] INST_BASE_FUNCT7 = 7'b0000000;
    localparam logic [6:0] INST_ALT_FUNCT7  = 7'b0100000;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP =
        {12'd0, 5'd0, INST_ADD_FUNCT, 5'd0, OPCODE_OP_IMM};

    // Descriptor kinds; codes 6 and 7 are undefined and encode as illegal.
    typedef enum logic [2:0] {
        ENC_LW     = 3'd0,
        ENC_SW     = 3'd1,
        ENC_OP     = 3'd2,
        ENC_OP_IMM = 3'd3,
        ENC_BRANCH = 3'd4,
        ENC_JAL    = 3'd5
    } enc_kind_e;

    // One FIFO entry: encoded word plus "replaced an illegal descriptor".
    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } enc_entry_t;

    typedef struct packed {
        logic       ok;
        logic [2:0] funct3;
        logic       alt;    // funct7 = ALT
        logic       shift;  // immediate form carries a 5-bit shamt
    } alu_fields_t;

    typedef struct packed {
        logic       ok;
        logic [2:0] funct3;
    } br_fields_t;

    // R-type / I-type ALU op -> funct fields.
    function automatic alu_fields_t alu_fields(input logic [3:0] op);
        alu_fields_t f;
        f = '{ok: 1'b1, funct3: INST_ADD_FUNCT, alt: 1'b0, shift: 1'b0};
        case (op)
            ALU_ADD:  f.funct3 = INST_ADD_FUNCT;
            ALU_SUB:  begin f.funct3 = INST_ADD_FUNCT; f.alt = 1'b1; end
            ALU_SLL:  begin f.funct3 = INST_SLL_FUNCT; f.shift = 1'b1; end
            ALU_SLT:  f.funct3 = INST_SLT_FUNCT;
            ALU_SLTU: f.funct3 = INST_SLTU_FUNCT;
            ALU_XOR:  f.funct3 = INST_XOR_FUNCT;
            ALU_SRL:  begin f.funct3 = INST_SR_FUNCT; f.shift = 1'b1; end
            ALU_SRA:  begin f.funct3 = INST_SR_FUNCT; f.shift = 1'b1; f.alt = 1'b1; end
            ALU_OR:   f.funct3 = INST_OR_FUNCT;
            ALU_AND:  f.funct3 = INST_AND_FUNCT;
            default:  f.ok = 1'b0;
        endcase
        return f;
    endfunction

    // Compare op -> branch funct3.
    function automatic br_fields_t br_fields(input logic [3:0] op);
        br_fields_t f;
        f = '{ok: 1'b1, funct3: INST_BEQ_FUNCT};
        case (op)
            ALU_SEQ:  f.funct3 = INST_BEQ_FUNCT;
            ALU_SNE:  f.funct3 = INST_BNE_FUNCT;
            ALU_SLT:  f.funct3 = INST_BLT_FUNCT;
            ALU_SGE:  f.funct3 = INST_BGE_FUNCT;
            ALU_SLTU: f.funct3 = INST_BLTU_FUNCT;
            ALU_SGEU: f.funct3 = INST_BGEU_FUNCT;
            default:  f.ok = 1'b0;
        endcase
        return f;
    endfunction

    // True when v is representable as a two's-complement value of 'bits' bits:
    // everything from bit bits-1 upward must be a copy of the sign.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] hi;
        hi = 32'($signed(v) >>> (bits - 1));
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// encode_fifo: DEPTH-entry synchronous FIFO for encoded words.
// Ports: clock/reset (async, active-high), flush (sync clear, wins over
// push/pop), push/wdata, pop/rdata, full, empty. rdata reads 0 while empty
// so the downstream word shows a clean value when nothing is valid.
module encode_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 33
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by plain overflow.
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only observed through count/empty.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I encoder (inverse of the decode stage).
// Ports: clock, reset (async, active-high), flush (sync clear);
// input descriptor in_valid/in_ready, in_kind, in_alu_op, in_rd, in_rs1,
// in_rs2, in_imm; output word out_valid/out_ready, out_instr, out_addr,
// out_err; err_count = saturating count of illegal descriptors accepted.
// Illegal descriptors are still accepted and emitted as a NOP with err set.
// JAL ignores in_alu_op.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_kind,
    input  logic [3:0]  in_alu_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [7:0]  err_count
);
    logic        legal;
    logic [31:0] enc_word;
    alu_fields_t af;
    br_fields_t  bf;
    enc_entry_t  wr_entry;
    enc_entry_t  rd_entry;
    logic        push, pop, fifo_full, fifo_empty;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    // ---------------- combinational encode + legality ----------------
    always_comb begin
        legal    = 1'b0;
        enc_word = INSTR_NOP;
        af       = alu_fields(in_alu_op);
        bf       = br_fields(in_alu_op);
        case (in_kind)
            ENC_LW: begin
                legal    = (in_alu_op == ALU_ADD) && fits_signed(in_imm, 12);
                enc_word = {in_imm[11:0], in_rs1, INST_LW_FUNCT, in_rd, OPCODE_LOAD};
            end
            ENC_SW: begin
                legal    = (in_alu_op == ALU_ADD) && fits_signed(in_imm, 12);
                enc_word = {in_imm[11:5], in_rs2, in_rs1, INST_SW_FUNCT,
                            in_imm[4:0], OPCODE_STORE};
            end
            ENC_OP: begin
                legal    = af.ok;
                enc_word = {af.alt ? INST_ALT_FUNCT7 : INST_BASE_FUNCT7,
                            in_rs2, in_rs1, af.funct3, in_rd, OPCODE_OP};
            end
            ENC_OP_IMM: begin
                // Shift-immediates carry a shamt in imm[24:20]; funct7 fills
                // the rest of the I-immediate field (ALT for SRAI).
                legal = af.ok && (in_alu_op != ALU_SUB) &&
                        (af.shift ? (in_imm[31:5] == '0) : fits_signed(in_imm, 12));
                if (af.shift)
                    enc_word = {af.alt ? INST_ALT_FUNCT7 : INST_BASE_FUNCT7,
                                in_imm[4:0], in_rs1, af.funct3, in_rd, OPCODE_OP_IMM};
                else
                    enc_word = {in_imm[11:0], in_rs1, af.funct3, in_rd, OPCODE_OP_IMM};
            end
            ENC_BRANCH: begin
                legal    = bf.ok && fits_signed(in_imm, 13) && !in_imm[0];
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, bf.funct3,
                            in_imm[4:1], in_imm[11], OPCODE_BRANCH};
            end
            ENC_JAL: begin
                legal    = fits_signed(in_imm, 21) && !in_imm[0];
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, OPCODE_JAL};
            end
            default: legal = 1'b0;
        endcase
        wr_entry.err   = !legal;
        wr_entry.instr = legal ? enc_word : INSTR_NOP;
    end

    // ---------------- handshake ----------------
    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    encode_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(enc_entry_t))
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_instr = rd_entry.instr;
    assign out_err   = rd_entry.err;
    assign out_addr  = addr_q;
    assign err_count = err_cnt_q;

    // ---------------- address and error counters ----------------
    always_comb begin
        addr_d    = addr_q;
        err_cnt_d = err_cnt_q;
        if (flush) begin
            addr_d    = BASE_ADDR;
            err_cnt_d = '0;
        end else begin
            if (pop)
                addr_d = addr_q + 32'd4;
            if (push && wr_entry.err && (err_cnt_q != 8'hFF))
                err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q    <= BASE_ADDR;
            err_cnt_q <= '0;
        end else begin
            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed table of known encodings, directed
// backpressure/flush/reset sequences, and randomized traffic checked against
// a queue-based model that decodes every emitted word back into a descriptor.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]  in_kind;
    logic [3:0]  in_alu_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, out_instr, out_addr;
    logic [7:0]  err_count;

    always #5 clock = ~clock;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_alu_op(in_alu_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .err_count(err_count)
    );

    typedef struct packed {
        logic [2:0]  kind;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } desc_t;

    typedef struct packed {
        desc_t       d;
        logic [31:0] want;
        logic        err;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    desc_t       sb[$];
    desc_t       cur;
    logic [31:0] m_addr;
    int          m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_legal(input desc_t d);
        int si;
        si = $signed(d.imm);
        case (d.kind)
            ENC_LW, ENC_SW: return d.alu == ALU_ADD && si >= -2048 && si <= 2047;
            ENC_OP: return d.alu inside {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                                         ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};
            ENC_OP_IMM: begin
                if (d.alu inside {ALU_SLL, ALU_SRL, ALU_SRA}) return si >= 0 && si <= 31;
                return d.alu inside {ALU_ADD, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND}
                       && si >= -2048 && si <= 2047;
            end
            ENC_BRANCH: return d.alu inside {ALU_SEQ, ALU_SNE, ALU_SLT, ALU_SGE, ALU_SLTU,
                                             ALU_SGEU} && si >= -4096 && si <= 4094 && !d.imm[0];
            ENC_JAL: return si >= -(1 << 20) && si <= (1 << 20) - 2 && !d.imm[0];
            default: return 1'b0;
        endcase
    endfunction

    // Descriptor as the decoder would reconstruct it: fields a format does
    // not carry read back as 0, and JAL decodes with ALU_ADD.
    function automatic desc_t normalize(input desc_t d);
        desc_t n;
        n = d;
        case (d.kind)
            ENC_LW:     n.rs2 = '0;
            ENC_SW:     n.rd = '0;
            ENC_OP:     n.imm = '0;
            ENC_OP_IMM: n.rs2 = '0;
            ENC_BRANCH: n.rd = '0;
            ENC_JAL:    begin n.rs1 = '0; n.rs2 = '0; n.alu = ALU_ADD; end
            default:    ;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] r_alu(input logic [6:0] f7, input logic [2:0] f3);
        case ({f7, f3})
            {7'h00, 3'b000}: return ALU_ADD;
            {7'h20, 3'b000}: return ALU_SUB;
            {7'h00, 3'b001}: return ALU_SLL;
            {7'h00, 3'b010}: return ALU_SLT;
            {7'h00, 3'b011}: return ALU_SLTU;
            {7'h00, 3'b100}: return ALU_XOR;
            {7'h00, 3'b101}: return ALU_SRL;
            {7'h20, 3'b101}: return ALU_SRA;
            {7'h00, 3'b110}: return ALU_OR;
            {7'h00, 3'b111}: return ALU_AND;
            default:         return 4'hF;
        endcase
    endfunction

    // Independent RV32I decoder; anything malformed decodes with kind 7.
    function automatic desc_t decode(input logic [31:0] w);
        desc_t d;
        logic [2:0] f3;
        logic [6:0] f7;
        d  = '0;
        f3 = w[14:12];
        f7 = w[31:25];
        case (w[6:0])
            7'b0000011: begin
                d.kind = ENC_LW; d.alu = ALU_ADD; d.rd = w[11:7]; d.rs1 = w[19:15];
                d.imm = {{20{w[31]}}, w[31:20]};
                if (f3 != 3'b010) d.kind = 3'd7;
            end
            7'b0100011: begin
                d.kind = ENC_SW; d.alu = ALU_ADD; d.rs1 = w[19:15]; d.rs2 = w[24:20];
                d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
                if (f3 != 3'b010) d.kind = 3'd7;
            end
            7'b0110011: begin
                d.kind = ENC_OP; d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
                d.alu = r_alu(f7, f3);
            end
            7'b0010011: begin
                d.kind = ENC_OP_IMM; d.rd = w[11:7]; d.rs1 = w[19:15];
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    d.alu = r_alu(f7, f3);
                    d.imm = {27'd0, w[24:20]};
                end else begin
                    d.alu = r_alu(7'h00, f3);
                    d.imm = {{20{w[31]}}, w[31:20]};
                end
            end
            7'b1100011: begin
                d.kind = ENC_BRANCH; d.rs1 = w[19:15]; d.rs2 = w[24:20];
                case (f3)
                    3'b000:  d.alu = ALU_SEQ;
                    3'b001:  d.alu = ALU_SNE;
                    3'b100:  d.alu = ALU_SLT;
                    3'b101:  d.alu = ALU_SGE;
                    3'b110:  d.alu = ALU_SLTU;
                    3'b111:  d.alu = ALU_SGEU;
                    default: d.alu = 4'hF;
                endcase
                d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            7'b1101111: begin
                d.kind = ENC_JAL; d.alu = ALU_ADD; d.rd = w[11:7];
                d.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            default: d.kind = 3'd7;
        endcase
        return d;
    endfunction

    // ---------------- drive / step ----------------
    task automatic drive(input desc_t d, input logic v);
        cur       = d;
        in_kind   = d.kind;
        in_alu_op = d.alu;
        in_rd     = d.rd;
        in_rs1    = d.rs1;
        in_rs2    = d.rs2;
        in_imm    = d.imm;
        in_valid  = v;
    endtask

    function automatic desc_t mk(input logic [2:0] k, input logic [3:0] a, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input int imm);
        desc_t d;
        d.kind = k; d.alu = a; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2; d.imm = 32'(imm);
        return d;
    endfunction

    task automatic check_outputs();
        desc_t h;
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
        chk("err_count", 64'(err_count), 64'(m_err));
        if (sb.size() != 0) begin
            h = sb[0];
            chk("out_addr", 64'(out_addr), 64'(m_addr));
            if (ref_legal(h)) begin
                chk("out_err_legal", 64'(out_err), 64'd0);
                chk("roundtrip", 64'(decode(out_instr)), 64'(normalize(h)));
            end else begin
                chk("nop_instr", 64'(out_instr), 64'h13);
                chk("out_err_illegal", 64'(out_err), 64'd1);
            end
        end
    endtask

    // Called at a negedge; checks, lets one rising edge pass, updates model.
    task automatic step();
        bit acc, pp;
        check_outputs();
        acc = in_valid && (sb.size() < DEPTH) && !flush;
        pp  = (sb.size() > 0) && out_ready && !flush;
        @(posedge clock);
        #1;
        if (flush) begin
            sb.delete();
            m_addr = BASE;
            m_err  = 0;
        end else begin
            if (pp) begin
                void'(sb.pop_front());
                m_addr = m_addr + 32'd4;
            end
            if (acc) begin
                sb.push_back(cur);
                if (!ref_legal(cur) && m_err < 255) m_err++;
            end
        end
        @(negedge clock);
    endtask

    function automatic desc_t rand_desc();
        desc_t d;
        int bl[15] = '{-4097, -4096, -2049, -2048, 2047, 2048, 4094, 4095, 4096,
                       -1048576, -1048578, 1048574, 1048576, 31, 32};
        d.kind = 3'($urandom_range(0, 7));
        d.alu  = 4'($urandom_range(0, 15));
        d.rd   = 5'($urandom);
        d.rs1  = 5'($urandom);
        d.rs2  = 5'($urandom);
        case ($urandom_range(0, 3))
            0:       d.imm = 32'(int'($urandom_range(0, 40)) - 20);
            1:       d.imm = 32'(bl[$urandom_range(0, 14)]);
            2:       d.imm = $urandom;
            default: d.imm = 32'($urandom_range(0, 31));
        endcase
        return d;
    endfunction

    // ---------------- test ----------------
    vec_t tbl[12];

    initial begin
        tbl[0]  = '{mk(ENC_LW,     ALU_ADD, 5, 2, 0, 8),  32'h00812283, 1'b0};
        tbl[1]  = '{mk(ENC_SW,     ALU_ADD, 0, 2, 5, 12), 32'h00512623, 1'b0};
        tbl[2]  = '{mk(ENC_OP_IMM, ALU_ADD, 1, 0, 0, 5),  32'h00500093, 1'b0};
        tbl[3]  = '{mk(ENC_OP,     ALU_ADD, 3, 1, 2, 0),  32'h002081B3, 1'b0};
        tbl[4]  = '{mk(ENC_OP,     ALU_SUB, 3, 1, 2, 0),  32'h402081B3, 1'b0};
        tbl[5]  = '{mk(ENC_OP_IMM, ALU_SRA, 1, 2, 0, 3),  32'h40315093, 1'b0};
        tbl[6]  = '{mk(ENC_BRANCH, ALU_SEQ, 0, 1, 2, -4), 32'hFE208EE3, 1'b0};
        tbl[7]  = '{mk(ENC_JAL,    ALU_ADD, 1, 0, 0, 8),  32'h008000EF, 1'b0};
        tbl[8]  = '{mk(ENC_BRANCH, ALU_SEQ, 0, 1, 2, 3),  32'h00000013, 1'b1};
        tbl[9]  = '{mk(ENC_OP_IMM, ALU_SUB, 1, 2, 0, 1),  32'h00000013, 1'b1};
        tbl[10] = '{mk(3'd7,       ALU_ADD, 1, 2, 3, 0),  32'h00000013, 1'b1};
        tbl[11] = '{mk(ENC_OP,     ALU_AND, 7, 6, 5, 0),  32'h005373B3, 1'b0};

        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive('0, 1'b0);
        sb.delete(); m_addr = BASE; m_err = 0;
        #12;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_addr",  64'(out_addr),  64'(BASE));
        chk("rst_out_err",   64'(out_err),   64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Known encodings, two at a time, popped back to back.
        for (int i = 0; i < 12; i += 2) begin
            out_ready = 1'b0;
            drive(tbl[i].d, 1'b1);   step();
            drive(tbl[i+1].d, 1'b1); step();
            in_valid = 1'b0;
            chk("tbl_instr", 64'(out_instr), 64'(tbl[i].want));
            chk("tbl_err",   64'(out_err),   64'(tbl[i].err));
            chk("tbl_addr",  64'(out_addr),  64'(BASE + 32'(4 * i)));
            out_ready = 1'b1; step();
            chk("tbl_instr", 64'(out_instr), 64'(tbl[i+1].want));
            chk("tbl_err",   64'(out_err),   64'(tbl[i+1].err));
            chk("tbl_addr",  64'(out_addr),  64'(BASE + 32'(4 * (i + 1))));
            step();
            out_ready = 1'b0;
        end
        chk("tbl_err_count", 64'(err_count), 64'd3);

        // Backpressure: fill, then pop+push while full must refuse the push.
        out_ready = 1'b0;
        drive(mk(ENC_OP, ALU_XOR, 4, 5, 6, 0), 1'b1);       step();
        drive(mk(ENC_OP_IMM, ALU_OR, 7, 8, 0, -1), 1'b1);   step();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        drive(mk(ENC_JAL, ALU_ADD, 9, 0, 0, -2048), 1'b1);
        out_ready = 1'b1;                                   step();
        chk("refused_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive(rand_desc(), ($urandom_range(0, 3) != 0));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            step();
        end
        flush = 1'b0;

        // Saturate err_count.
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive(mk(3'd7, ALU_ADD, 1, 1, 1, 0), 1'b1);
            step();
        end
        in_valid = 1'b0;
        step(); step();
        chk("err_sat", 64'(err_count), 64'd255);

        // Flush with FIFO full and a descriptor presented.
        out_ready = 1'b0;
        drive(mk(ENC_LW, ALU_ADD, 1, 2, 0, 4), 1'b1); step();
        drive(mk(ENC_SW, ALU_ADD, 0, 2, 3, 4), 1'b1); step();
        drive(mk(ENC_OP, ALU_ADD, 1, 2, 3, 0), 1'b1);
        flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_addr",  64'(out_addr),  64'(BASE));
        chk("flush_err_count", 64'(err_count), 64'd0);
        step();

        // Async reset between edges with entries and a nonzero address.
        out_ready = 1'b1;
        drive(mk(ENC_OP, ALU_ADD, 1, 2, 3, 0), 1'b1); step();
        drive(mk(3'd6, ALU_ADD, 1, 2, 3, 0), 1'b1);   step();
        out_ready = 1'b0;
        drive(mk(ENC_OP, ALU_OR, 1, 2, 3, 0), 1'b1);  step();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready",  64'(in_ready),  64'd1);
        chk("arst_out_instr", 64'(out_instr), 64'd0);
        chk("arst_out_addr",  64'(out_addr),  64'(BASE));
        chk("arst_out_err",   64'(out_err),   64'd0);
        chk("arst_err_count", 64'(err_count), 64'd0);
        sb.delete(); m_addr = BASE; m_err = 0;
        #1 reset = 1'b0;
        @(negedge clock);
        drive(mk(ENC_JAL, ALU_ADD, 1, 0, 0, 8), 1'b1); step();
        in_valid = 1'b0;
        chk("post_rst_addr",  64'(out_addr),  64'(BASE));
        chk("post_rst_instr", 64'(out_instr), 64'h008000EF);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
